// File: rtl/mmio_regfile.sv
// rtl/mmio_regfile.sv - problem-state MMIO responder: ID, scratch and status registers
// Optional request parity checking and error counting under `define MMIO_PARITY_CHECK_EN.
module mmio_regfile #(
  parameter int          NUM_REGS = 8,
  parameter int          LATENCY  = 2,
  parameter logic [0:63] AFU_ID   = 64'h0000_CAFE_0000_0001
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        mmio_valid,
  input  logic        mmio_cfg,
  input  logic        mmio_read,
  input  logic        mmio_dw,
  input  logic [0:23] mmio_address,
  input  logic        mmio_address_parity,
  input  logic [0:63] mmio_wdata,
  input  logic        mmio_wdata_parity,
  output logic        ack,
  output logic [0:63] rdata,
  output logic        rdata_parity
);

  localparam int IDX_W = $clog2(NUM_REGS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             req_read_q, req_read_d;
  logic             req_dw_q, req_dw_d;
  logic             req_word_q, req_word_d;
  logic             req_err_q, req_err_d;
  logic [IDX_W-1:0] req_idx_q, req_idx_d;
  logic [0:63]      req_wdata_q, req_wdata_d;
  logic             sticky_q, sticky_d;
  logic             ack_q, ack_d;
  logic [0:63]      rdata_q, rdata_d;
  logic [0:63]      regs_q [NUM_REGS];
  logic [0:63]      regs_d [NUM_REGS];
  logic [31:0]      err_count;

  logic             accept;
  logic             capture;
  logic             par_err;
  logic             enter_resp;
  logic [0:63]      slot_val;
  logic [0:31]      slot_word;
  logic [0:63]      resp_val;
  logic             unused_in;

  assign accept  = mmio_valid & ~mmio_cfg;
  assign capture = accept && (state_q == S_IDLE);

`ifdef MMIO_PARITY_CHECK_EN
  logic [31:0] perr_cnt_q, perr_cnt_d;

  assign par_err = (mmio_address_parity != ~^mmio_address) |
                   (~mmio_read & (mmio_wdata_parity != ~^mmio_wdata));

  always_comb begin
    perr_cnt_d = perr_cnt_q;
    if (capture && par_err && (perr_cnt_q != 32'hFFFF_FFFF)) begin
      perr_cnt_d = perr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) perr_cnt_q <= '0;
    else          perr_cnt_q <= perr_cnt_d;
  end

  assign err_count = perr_cnt_q;
`else
  assign par_err   = 1'b0;
  assign err_count = 32'h0;
`endif

  assign unused_in = ^{mmio_address_parity, mmio_wdata_parity, mmio_address[0:22-IDX_W]};

  // The _d view of the request is the one being answered, which lets LATENCY=1 respond straight from IDLE.
  always_comb begin
    req_read_d  = req_read_q;
    req_dw_d    = req_dw_q;
    req_word_d  = req_word_q;
    req_err_d   = req_err_q;
    req_idx_d   = req_idx_q;
    req_wdata_d = req_wdata_q;
    if (capture) begin
      req_read_d  = mmio_read;
      req_dw_d    = mmio_dw;
      req_word_d  = mmio_address[23];
      req_err_d   = par_err;
      req_idx_d   = mmio_address[23-IDX_W:22];
      req_wdata_d = mmio_wdata;
    end
  end

  always_comb begin
    if (req_idx_d == IDX_W'(0)) begin
      slot_val = AFU_ID;
    end else if (req_idx_d == IDX_W'(NUM_REGS - 1)) begin
      slot_val = {31'b0, sticky_q, err_count};
    end else begin
      slot_val = regs_q[req_idx_d];
    end
    slot_word = req_word_d ? slot_val[32:63] : slot_val[0:31];
    resp_val  = '0;
    if (!req_err_d && !(req_dw_d && req_word_d)) begin
      resp_val = req_dw_d ? slot_val : {slot_word, slot_word};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    ack_d      = 1'b0;
    rdata_d    = '0;
    enter_resp = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (accept) sticky_d = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (accept) sticky_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_resp) begin
      ack_d = 1'b1;
      if (req_read_d) begin
        rdata_d = resp_val;
      end else if (!req_err_d && !(req_dw_d && req_word_d) &&
                   (req_idx_d != IDX_W'(0)) && (req_idx_d != IDX_W'(NUM_REGS - 1))) begin
        if (req_dw_d)        regs_d[req_idx_d]        = req_wdata_d;
        else if (req_word_d) regs_d[req_idx_d][32:63] = req_wdata_d[32:63];
        else                 regs_d[req_idx_d][0:31]  = req_wdata_d[32:63];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_read_q  <= 1'b0;
      req_dw_q    <= 1'b0;
      req_word_q  <= 1'b0;
      req_err_q   <= 1'b0;
      req_idx_q   <= '0;
      req_wdata_q <= '0;
      sticky_q    <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_read_q  <= req_read_d;
      req_dw_q    <= req_dw_d;
      req_word_q  <= req_word_d;
      req_err_q   <= req_err_d;
      req_idx_q   <= req_idx_d;
      req_wdata_q <= req_wdata_d;
      sticky_q    <= sticky_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign ack          = ack_q;
  assign rdata        = rdata_q;
  assign rdata_parity = ~^rdata_q;

endmodule

// File: doc/mmio_regfile.md
Name: mmio_regfile

Overview:
- Problem-state MMIO responder for the AFU. Handles every PSL MMIO request with cfg=0; the descriptor-space responder handles cfg=1 requests.
- Holds a small bank of 64-bit registers (ID, scratch, status) and checks request parity.
- Returns ack, data and data parity back toward the PSL. Its output is OR-merged with the descriptor responder output.

Parameters:
- NUM_REGS, 8, number of 64-bit register slots (power of two, 4..64).
- LATENCY, 2, cycles from accepted request to ack (1..8).
- AFU_ID, 64'h0000_CAFE_0000_0001, read-only value of reg 0.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mmio_valid  in  1  request strobe, one cycle per request.
- mmio_cfg  in  1  1 = descriptor space; this block ignores such requests.
- mmio_read  in  1  1 = read, 0 = write.
- mmio_dw  in  1  1 = 64-bit access, 0 = 32-bit access.
- mmio_address  in  [0:23]  word address, bit 0 is the MSB.
- mmio_address_parity  in  1  odd parity over mmio_address.
- mmio_wdata  in  [0:63]  write data (32-bit writes use [32:63]).
- mmio_wdata_parity  in  1  odd parity over mmio_wdata.
- ack  out  1  one-cycle response strobe.
- rdata  out  [0:63]  read data.
- rdata_parity  out  1  odd parity over rdata (~^rdata).

Behaviour:
Decode
- Request is accepted when mmio_valid=1 and mmio_cfg=0.
- Slot index = low log2(NUM_REGS) bits of mmio_address[0:22].
- mmio_address[23] selects the word within the dword: 0 = [0:31], 1 = [32:63].
- A dw access with address[23]=1 is misaligned: it is acked, it has no write effect, and a read returns 0.
- Address bits above the slot index are ignored, so the register bank aliases.

Register map
- Reg 0: AFU_ID, read-only.
- Regs 1..NUM_REGS-2: read/write scratch, reset to 0.
- Reg NUM_REGS-1: status, read-only.
  - [32:63]: parity error count, saturates at 32'hFFFF_FFFF.
  - [31]: sticky protocol error flag.
  - Other bits read 0.
- Writes to read-only slots are acked and discarded.

Access widths
- 32-bit write updates only the selected word of the slot, taking data from mmio_wdata[32:63].
- 32-bit read returns the selected word replicated in both halves of rdata.

FSM
- States: IDLE, WAIT, RESP.
- IDLE: on an accepted request, capture the request and load cnt=LATENCY-1.
  - LATENCY=1: go directly to RESP.
  - Otherwise: go to WAIT.
- WAIT: decrement cnt; go to RESP when cnt reaches 0.
- RESP: drive ack=1 for exactly one cycle with read data registered, then return to IDLE.
- Net effect: ack rises exactly LATENCY cycles after the valid cycle.
- The write takes effect on the clock edge that enters RESP. A read issued in the cycle after that ack observes the new value.

Protocol violations
- An accepted request arriving while in WAIT or RESP is dropped (never acked) and sets the sticky flag.
- The sticky flag clears only on reset.

Outputs
- Outside RESP, and for writes: rdata=0, rdata_parity=1.
- rdata_parity is always ~^rdata.

Reset
- Asynchronous, active-low. Any in-flight request is discarded with no ack.
- Reset values: ack=0, rdata=0, rdata_parity=1, scratch registers=0, count=0, sticky flag=0, state=IDLE.

Optional Feature:
MMIO_PARITY_CHECK_EN
- Defined:
  - Address parity error (mmio_address_parity != ~^mmio_address) or write-data parity error on a write, checked at acceptance.
  - Effect: the write is suppressed and a read returns 0.
  - The request is still acked on schedule.
  - The count increments by 1 per errored request (address and data errors together count once), saturating.
- Undefined:
  - Parity inputs are ignored.
  - Count bits read constant 0.

Test Plan:
- Reset then read reg 0 (address 24'h000000, dw=1) -> ack exactly 2 cycles after valid, rdata=64'h0000_CAFE_0000_0001, rdata_parity=~^rdata.
- dw write 64'h1122_3344_5566_7788 to reg 1 (address 24'h000002), then 32-bit write 32'hAABB_CCDD to address 24'h000003, then dw read reg 1 -> 64'h1122_3344_AABB_CCDD; each ack one cycle wide.
- 32-bit read at address 24'h000002 after the above -> rdata=64'h1122_3344_1122_3344.
- Second valid issued 1 cycle after the first (LATENCY=2) -> only the first is acked; status read returns bit 31 set; bit stays set until reset_n pulses low.
- With MMIO_PARITY_CHECK_EN: write reg 2 with a flipped mmio_wdata_parity -> acked, reg 2 still 0, status [32:63]=1. Repeat with a bad address parity on a read -> rdata=0, count=2.
- Assert reset_n low during WAIT of a write to reg 3 -> no ack, reg 3=0, outputs at reset values immediately (asynchronous).
